// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and EX-side registered outputs of the ID/EX stage
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            if_id_valid_i;
  logic [XLEN-1:0] if_id_pc_i;
  logic [4:0]      if_id_rs1_i;
  logic [4:0]      if_id_rs2_i;
  logic [4:0]      if_id_rd_i;
  logic            if_id_use_rs1_i;
  logic            if_id_use_rs2_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [XLEN-1:0] imm_i;
  logic            regwrite_i;
  logic            memread_i;
  logic            memwrite_i;
  logic            memtoreg_i;
  logic            alusrc_i;
  logic            branch_i;
  logic [1:0]      aluop_i;

  logic            id_ex_valid_o;
  logic [XLEN-1:0] id_ex_pc_o;
  logic [XLEN-1:0] id_ex_rs1_data_o;
  logic [XLEN-1:0] id_ex_rs2_data_o;
  logic [XLEN-1:0] id_ex_imm_o;
  logic [4:0]      id_ex_rs1_o;
  logic [4:0]      id_ex_rs2_o;
  logic [4:0]      id_ex_rd_o;
  logic            id_ex_regwrite_o;
  logic            id_ex_memread_o;
  logic            id_ex_memwrite_o;
  logic            id_ex_memtoreg_o;
  logic            id_ex_alusrc_o;
  logic            id_ex_branch_o;
  logic [1:0]      id_ex_aluop_o;

  modport master (
    output if_id_valid_i, if_id_pc_i, if_id_rs1_i, if_id_rs2_i, if_id_rd_i,
           if_id_use_rs1_i, if_id_use_rs2_i, rs1_data_i, rs2_data_i, imm_i,
           regwrite_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, branch_i, aluop_i,
    input  id_ex_valid_o, id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
           id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o, id_ex_regwrite_o, id_ex_memread_o,
           id_ex_memwrite_o, id_ex_memtoreg_o, id_ex_alusrc_o, id_ex_branch_o, id_ex_aluop_o
  );

  modport slave (
    input  if_id_valid_i, if_id_pc_i, if_id_rs1_i, if_id_rs2_i, if_id_rd_i,
           if_id_use_rs1_i, if_id_use_rs2_i, rs1_data_i, rs2_data_i, imm_i,
           regwrite_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, branch_i, aluop_i,
    output id_ex_valid_o, id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
           id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o, id_ex_regwrite_o, id_ex_memread_o,
           id_ex_memwrite_o, id_ex_memtoreg_o, id_ex_alusrc_o, id_ex_branch_o, id_ex_aluop_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
// Optional saturating bubble counter enabled by ID_EX_STALL_CNT_EN.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hold_i,
  input  logic             flush_i,
  id_ex_stage_if.slave     bus,
`ifdef ID_EX_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
`endif
  output logic             stall_o
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic            branch;
    logic [1:0]      aluop;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  logic luh;
  logic ctl_en;

  assign luh = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & bus.if_id_valid_i &
               ((bus.if_id_use_rs1_i & (ex_q.rd == bus.if_id_rs1_i)) |
                (bus.if_id_use_rs2_i & (ex_q.rd == bus.if_id_rs2_i)));

  assign stall_o = luh & ~flush_i & ~hold_i;
  assign ctl_en  = bus.if_id_valid_i;

  // Bubbles clear every field so the forwarding unit can never match one.
  always_comb begin
    ex_d = ex_q;
    if (!hold_i) begin
      if (flush_i || luh) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = bus.if_id_valid_i;
        ex_d.pc       = bus.if_id_pc_i;
        ex_d.rs1_data = bus.rs1_data_i;
        ex_d.rs2_data = bus.rs2_data_i;
        ex_d.imm      = bus.imm_i;
        ex_d.rs1      = bus.if_id_rs1_i;
        ex_d.rs2      = bus.if_id_rs2_i;
        ex_d.rd       = bus.if_id_rd_i;
        ex_d.regwrite = bus.regwrite_i & ctl_en;
        ex_d.memread  = bus.memread_i  & ctl_en;
        ex_d.memwrite = bus.memwrite_i & ctl_en;
        ex_d.memtoreg = bus.memtoreg_i & ctl_en;
        ex_d.alusrc   = bus.alusrc_i   & ctl_en;
        ex_d.branch   = bus.branch_i   & ctl_en;
        ex_d.aluop    = bus.aluop_i    & {2{ctl_en}};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.id_ex_valid_o    = ex_q.valid;
  assign bus.id_ex_pc_o       = ex_q.pc;
  assign bus.id_ex_rs1_data_o = ex_q.rs1_data;
  assign bus.id_ex_rs2_data_o = ex_q.rs2_data;
  assign bus.id_ex_imm_o      = ex_q.imm;
  assign bus.id_ex_rs1_o      = ex_q.rs1;
  assign bus.id_ex_rs2_o      = ex_q.rs2;
  assign bus.id_ex_rd_o       = ex_q.rd;
  assign bus.id_ex_regwrite_o = ex_q.regwrite;
  assign bus.id_ex_memread_o  = ex_q.memread;
  assign bus.id_ex_memwrite_o = ex_q.memwrite;
  assign bus.id_ex_memtoreg_o = ex_q.memtoreg;
  assign bus.id_ex_alusrc_o   = ex_q.alusrc;
  assign bus.id_ex_branch_o   = ex_q.branch;
  assign bus.id_ex_aluop_o    = ex_q.aluop;

`ifdef ID_EX_STALL_CNT_EN
  // Counts only edges where the load-use bubble wins; hold and flush take precedence.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (!hold_i && !flush_i && luh && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk_i;
  logic rst_n_i;
  logic hold_i;
  logic flush_i;
  logic stall_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o;
`endif

  int checks;
  int errors;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .bus     (bus.slave),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .stall_o (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    bus.if_id_valid_i   = 1'b0;
    bus.if_id_pc_i      = '0;
    bus.if_id_rs1_i     = '0;
    bus.if_id_rs2_i     = '0;
    bus.if_id_rd_i      = '0;
    bus.if_id_use_rs1_i = 1'b0;
    bus.if_id_use_rs2_i = 1'b0;
    bus.rs1_data_i      = '0;
    bus.rs2_data_i      = '0;
    bus.imm_i           = '0;
    bus.regwrite_i      = 1'b0;
    bus.memread_i       = 1'b0;
    bus.memwrite_i      = 1'b0;
    bus.memtoreg_i      = 1'b0;
    bus.alusrc_i        = 1'b0;
    bus.branch_i        = 1'b0;
    bus.aluop_i         = 2'b00;
  endtask

  task automatic set_load(input logic [XLEN-1:0] pc, input logic [4:0] rd);
    idle();
    bus.if_id_valid_i   = 1'b1;
    bus.if_id_pc_i      = pc;
    bus.if_id_rs1_i     = 5'd2;
    bus.if_id_use_rs1_i = 1'b1;
    bus.if_id_rd_i      = rd;
    bus.imm_i           = 32'd16;
    bus.regwrite_i      = 1'b1;
    bus.memread_i       = 1'b1;
    bus.memtoreg_i      = 1'b1;
    bus.alusrc_i        = 1'b1;
  endtask

  task automatic set_alu(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic use1, input logic use2);
    idle();
    bus.if_id_valid_i   = 1'b1;
    bus.if_id_pc_i      = pc;
    bus.if_id_rs1_i     = rs1;
    bus.if_id_rs2_i     = rs2;
    bus.if_id_rd_i      = rd;
    bus.if_id_use_rs1_i = use1;
    bus.if_id_use_rs2_i = use2;
    bus.rs1_data_i      = pc + 32'd1;
    bus.rs2_data_i      = pc + 32'd2;
    bus.regwrite_i      = 1'b1;
    bus.aluop_i         = 2'b10;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n_i = 1'b0;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    idle();
    bus.if_id_valid_i = 1'b1;
    bus.if_id_pc_i    = $urandom;
    bus.if_id_rd_i    = 5'd5;
    bus.memread_i     = 1'b1;
    bus.regwrite_i    = 1'b1;
    bus.rs1_data_i    = $urandom;

    // Reset with live inputs
    repeat (3) tick();
    check("rst_valid", 64'(bus.id_ex_valid_o), 64'd0);
    check("rst_pc", 64'(bus.id_ex_pc_o), 64'd0);
    check("rst_memread", 64'(bus.id_ex_memread_o), 64'd0);
    check("rst_rd", 64'(bus.id_ex_rd_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    bus.if_id_pc_i = 32'h100;
    rst_n_i = 1'b1;
    #1;
    check("rel_pc_before_edge", 64'(bus.id_ex_pc_o), 64'd0);
    tick();
    check("first_capture_pc", 64'(bus.id_ex_pc_o), 64'h100);
    check("first_capture_valid", 64'(bus.id_ex_valid_o), 64'd1);

    // Invalid instruction captures control as zero
    bus.if_id_valid_i = 1'b0;
    bus.if_id_pc_i    = 32'h104;
    tick();
    check("inv_regwrite", 64'(bus.id_ex_regwrite_o), 64'd0);
    check("inv_memread", 64'(bus.id_ex_memread_o), 64'd0);
    check("inv_pc", 64'(bus.id_ex_pc_o), 64'h104);

    // Load-use on rs1
    set_load(32'h200, 5'd5);
    tick();
    check("lw_memread", 64'(bus.id_ex_memread_o), 64'd1);
    check("lw_rd", 64'(bus.id_ex_rd_o), 64'd5);
    set_alu(32'h204, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1);
    #1;
    check("lu_stall", 64'(stall_o), 64'd1);
    tick();
    check("bubble_valid", 64'(bus.id_ex_valid_o), 64'd0);
    check("bubble_regwrite", 64'(bus.id_ex_regwrite_o), 64'd0);
    check("bubble_rd", 64'(bus.id_ex_rd_o), 64'd0);
    check("bubble_rs1", 64'(bus.id_ex_rs1_o), 64'd0);
    check("bubble_no_restall", 64'(stall_o), 64'd0);
    tick();
    check("add_valid", 64'(bus.id_ex_valid_o), 64'd1);
    check("add_rs1", 64'(bus.id_ex_rs1_o), 64'd5);
    check("add_pc", 64'(bus.id_ex_pc_o), 64'h204);
    check("add_rd", 64'(bus.id_ex_rd_o), 64'd7);
    check("add_rs1_data", 64'(bus.id_ex_rs1_data_o), 64'h205);
    check("add_aluop", 64'(bus.id_ex_aluop_o), 64'd2);
    check("add_stall", 64'(stall_o), 64'd0);

    // lw x0 never stalls
    set_load(32'h300, 5'd0);
    tick();
    set_alu(32'h304, 5'd0, 5'd1, 5'd3, 1'b1, 1'b0);
    #1;
    check("x0_stall", 64'(stall_o), 64'd0);
    tick();
    check("x0_consumer_valid", 64'(bus.id_ex_valid_o), 64'd1);

    // rs2 match without use_rs2 does not stall
    set_load(32'h400, 5'd5);
    tick();
    set_alu(32'h404, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0);
    #1;
    check("nouse_rs2_stall", 64'(stall_o), 64'd0);
    tick();
    check("nouse_rs2_valid", 64'(bus.id_ex_valid_o), 64'd1);
    check("nouse_rs2_field", 64'(bus.id_ex_rs2_o), 64'd5);

    // rs2 match with use_rs2 stalls
    set_load(32'h480, 5'd9);
    tick();
    set_alu(32'h484, 5'd3, 5'd9, 5'd8, 1'b1, 1'b1);
    #1;
    check("use_rs2_stall", 64'(stall_o), 64'd1);
    tick();
    check("use_rs2_bubble", 64'(bus.id_ex_valid_o), 64'd0);
    tick();

    // Flush while load-use pending
    set_load(32'h500, 5'd5);
    tick();
    set_alu(32'h504, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    check("flush_stall", 64'(stall_o), 64'd0);
    tick();
    check("flush_valid", 64'(bus.id_ex_valid_o), 64'd0);
    check("flush_memread", 64'(bus.id_ex_memread_o), 64'd0);
`ifdef ID_EX_STALL_CNT_EN
    check("flush_cnt", 64'(stall_cnt_o), 64'd2);
`endif
    flush_i = 1'b0;
    tick();

    // Hold overrides flush for 3 cycles
    set_alu(32'h600, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    tick();
    check("pre_hold_pc", 64'(bus.id_ex_pc_o), 64'h600);
    hold_i  = 1'b1;
    flush_i = 1'b1;
    set_alu(32'h700, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_pc_%0d", i), 64'(bus.id_ex_pc_o), 64'h600);
      check($sformatf("hold_valid_%0d", i), 64'(bus.id_ex_valid_o), 64'd1);
      check($sformatf("hold_rd_%0d", i), 64'(bus.id_ex_rd_o), 64'd9);
    end
    hold_i = 1'b0;
    tick();
    check("post_hold_valid", 64'(bus.id_ex_valid_o), 64'd0);
    check("post_hold_pc", 64'(bus.id_ex_pc_o), 64'd0);
    flush_i = 1'b0;

    // Reset in the middle of a stall
    set_load(32'h800, 5'd5);
    tick();
    set_alu(32'h804, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    #1;
    check("pre_rst_stall", 64'(stall_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_valid", 64'(bus.id_ex_valid_o), 64'd0);
    check("midrst_memread", 64'(bus.id_ex_memread_o), 64'd0);
`ifdef ID_EX_STALL_CNT_EN
    check("midrst_cnt", 64'(stall_cnt_o), 64'd0);
`endif
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle();
    tick();

`ifdef ID_EX_STALL_CNT_EN
    // 17 bubbles saturate a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      set_load(32'h900, 5'd5);
      tick();
      set_alu(32'h904, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
      tick();
      tick();
    end
    check("cnt_saturated", 64'(stall_cnt_o), 64'd15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection.
- Captures decode-stage operands, register indices and control bits each cycle.
- Feeds id_ex_rs1_o/id_ex_rs2_o to the EX-stage forwarding unit.
- Inserts exactly one bubble and stalls PC and IF/ID when a load in EX produces a register needed by the instruction in ID.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 32, width of the optional stall counter.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- hold_i  in  1  global pipeline freeze (memory wait); register contents held.
- flush_i  in  1  branch/jump taken in EX; kill the instruction entering EX.
- if_id_valid_i  in  1  IF/ID holds a real instruction.
- if_id_pc_i  in  XLEN  PC of the decoding instruction.
- if_id_rs1_i, if_id_rs2_i, if_id_rd_i  in  5 each  register indices.
- if_id_use_rs1_i, if_id_use_rs2_i  in  1 each  instruction reads that source.
- rs1_data_i, rs2_data_i  in  XLEN each  register file read data.
- imm_i  in  XLEN  decoded immediate.
- regwrite_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, branch_i  in  1 each  decoder control.
- aluop_i  in  2  ALU operation class.
- id_ex_valid_o  out  1  EX-stage instruction valid.
- id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o  out  XLEN each  registered copies.
- id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o  out  5 each  registered indices, to forwarding unit.
- id_ex_regwrite_o, id_ex_memread_o, id_ex_memwrite_o, id_ex_memtoreg_o, id_ex_alusrc_o, id_ex_branch_o  out  1 each  registered control.
- id_ex_aluop_o  out  2  registered ALU class.
- stall_o  out  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - All id_ex_* outputs return to 0, id_ex_valid_o included.
  - stall_o reads 0 while reset is asserted.
- Load-use detect, combinational:
  - luh = id_ex_valid_o & id_ex_memread_o & (id_ex_rd_o!=0) & if_id_valid_i & ((if_id_use_rs1_i & id_ex_rd_o==if_id_rs1_i) | (if_id_use_rs2_i & id_ex_rd_o==if_id_rs2_i)).
  - stall_o = luh & ~flush_i & ~hold_i.
- Per rising edge, in priority order:
  1. hold_i=1: every register keeps its value. hold_i overrides flush_i; the flush source is frozen too and re-presents flush after release.
  2. flush_i=1: bubble. valid, regwrite, memread, memwrite, branch become 0; other fields are don't-care but implemented as cleared to 0.
  3. luh=1: bubble, same as flush. The IF/ID instruction stays in place because upstream honours stall_o.
  4. Otherwise: capture all inputs. id_ex_valid_o <= if_id_valid_i. When if_id_valid_i=0, control bits are captured as 0.
- Latency: 1 cycle from input to id_ex_* output. A load-use pair costs exactly 1 bubble.
- The bubble has memread=0, so luh deasserts the next cycle. No back-to-back double stall from the same load.
- rd/rs fields of a bubble are 0, so the forwarding unit never matches a bubble.
- x0 as load destination never stalls.
- Reset mid-stall clears state immediately. stall_o drops in the same cycle reset asserts.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [CNT_W-1:0].
  - Increments on every clock edge where a load-use bubble is inserted (priority case 3 taken).
  - Saturates at all-ones.
  - Reset to 0 by rst_n_i.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n_i=0 with random inputs, then release -> all id_ex_* = 0 and stall_o=0 until the first capture edge; then id_ex_pc_o = if_id_pc_i of the prior cycle.
- Load-use on rs1: EX holds lw x5 (memread=1, rd=5, valid); ID has add with rs1=5, use_rs1=1.
  - Required: stall_o=1 for 1 cycle; next cycle id_ex_valid_o=0 and id_ex_regwrite_o=0.
  - Following cycle: the add is captured with id_ex_rs1_o=5, and stall_o=0.
- No false stall:
  - lw x0 followed by an rs1=0 consumer -> stall_o=0.
  - lw x5 followed by an instruction with rs2=5 but use_rs2_i=0 -> stall_o=0.
- Flush vs load-use: flush_i=1 while luh=1 -> stall_o=0, bubble inserted; stall_cnt_o not incremented (if enabled).
- Hold: hold_i=1 for 3 cycles while flush_i=1 -> outputs unchanged for 3 cycles; bubble appears on the first edge after hold_i falls.
- Counter (ID_EX_STALL_CNT_EN, CNT_W=4): 17 load-use bubbles -> stall_cnt_o=15, saturated.
